// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC request arbiter.
package cordic_pkg;
  localparam int CORDIC_W = 32;
  localparam int CORDIC_LATENCY = 16;
  localparam int MAX_REQ = 4;
  typedef logic [1:0] req_id_t;
endpackage

// File: rtl/cordic_arb_tagpipe.sv
// Tag shift register: carries {valid, requester id} alongside the core.
module cordic_arb_tagpipe
  import cordic_pkg::*;
#(
  parameter int LATENCY = CORDIC_LATENCY
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    valid,
  input  req_id_t id,
  output logic    ret_valid,
  output req_id_t ret_id
);

  logic [LATENCY-1:0] vq;
  req_id_t            iq [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vq <= '0;
      for (int i = 0; i < LATENCY; i++) iq[i] <= '0;
    end else begin
      vq[0] <= valid;
      iq[0] <= id;
      for (int i = 1; i < LATENCY; i++) begin
        vq[i] <= vq[i-1];
        iq[i] <= iq[i-1];
      end
    end
  end

  assign ret_valid = vq[LATENCY-1];
  assign ret_id    = iq[LATENCY-1];

endmodule

// File: rtl/cordic_arb.sv
// Round-robin arbiter feeding one pipelined CORDIC core; results routed by tag.
// Optional CORDIC_ARB_PERF_EN adds issue/stall counters.
module cordic_arb
  import cordic_pkg::*;
#(
  parameter int LATENCY = CORDIC_LATENCY,
  parameter int NREQ    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*CORDIC_W-1:0] req_dataa,
  input  logic [NREQ*CORDIC_W-1:0] req_datab,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          resp_valid,
  output logic [CORDIC_W-1:0]      resp_result,
  output logic                     cor_valid,
  output logic [CORDIC_W-1:0]      cor_dataa,
  output logic [CORDIC_W-1:0]      cor_datab,
  input  logic [CORDIC_W-1:0]      cor_result
`ifdef CORDIC_ARB_PERF_EN
  ,
  output logic [31:0]              perf_issued,
  output logic [31:0]              perf_stall
`endif
);

  logic [MAX_REQ-1:0]          v4;
  logic [MAX_REQ-1:0]          g4;
  logic [MAX_REQ-1:0]          oh4;
  logic [MAX_REQ*CORDIC_W-1:0] da4;
  logic [MAX_REQ*CORDIC_W-1:0] db4;
  req_id_t                     ptr;
  req_id_t                     gid;
  req_id_t                     idx;
  req_id_t                     cor_id;
  req_id_t                     tid;
  logic                        xfer;
  logic                        tv;

  // Search starts one past the last grant and wraps at NREQ-1.
  always_comb begin
    v4 = '0;
    v4[NREQ-1:0] = req_valid;
    da4 = '0;
    da4[NREQ*CORDIC_W-1:0] = req_dataa;
    db4 = '0;
    db4[NREQ*CORDIC_W-1:0] = req_datab;
    g4   = '0;
    gid  = ptr;
    idx  = ptr;
    xfer = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == req_id_t'(NREQ-1)) ? 2'd0 : idx + 2'd1;
      if (!xfer && v4[idx]) begin
        g4[idx] = 1'b1;
        gid     = idx;
        xfer    = 1'b1;
      end
    end
    if (rst) begin
      g4   = '0;
      xfer = 1'b0;
    end
  end

  assign req_ready = g4[NREQ-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= req_id_t'(NREQ-1);
      cor_valid <= 1'b0;
      cor_dataa <= '0;
      cor_datab <= '0;
      cor_id    <= '0;
    end else begin
      cor_valid <= xfer;
      if (xfer) begin
        ptr       <= gid;
        cor_dataa <= da4[{gid, 5'd0} +: CORDIC_W];
        cor_datab <= db4[{gid, 5'd0} +: CORDIC_W];
        cor_id    <= gid;
      end
    end
  end

  // Tag enters with cor_valid so it exits as cor_result settles.
  cordic_arb_tagpipe #(
    .LATENCY(LATENCY)
  ) u_tags (
    .clk      (clk),
    .rst      (rst),
    .valid    (cor_valid),
    .id       (cor_id),
    .ret_valid(tv),
    .ret_id   (tid)
  );

  assign oh4 = MAX_REQ'(1) << tid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid  <= '0;
      resp_result <= '0;
    end else begin
      resp_valid <= tv ? oh4[NREQ-1:0] : '0;
      if (tv) resp_result <= cor_result;
    end
  end

`ifdef CORDIC_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (xfer) perf_issued <= perf_issued + 32'd1;
      if (|req_valid && !xfer) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cordic_arb.sv
// Directed bench for cordic_arb with a behavioural fixed-latency core model.
// Define CORDIC_ARB_PERF_EN to also exercise the perf counters.
module tb_cordic_arb;
  localparam int L = 16;
  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*32-1:0] req_dataa;
  logic [N*32-1:0] req_datab;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  resp_valid;
  logic [31:0]   resp_result;
  logic          cor_valid;
  logic [31:0]   cor_dataa;
  logic [31:0]   cor_datab;
  logic [31:0]   cor_result;
`ifdef CORDIC_ARB_PERF_EN
  logic [31:0]   perf_issued;
  logic [31:0]   perf_stall;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cordic_arb #(
    .LATENCY(L),
    .NREQ(N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_dataa  (req_dataa),
    .req_datab  (req_datab),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_result(resp_result),
    .cor_valid  (cor_valid),
    .cor_dataa  (cor_dataa),
    .cor_datab  (cor_datab),
    .cor_result (cor_result)
`ifdef CORDIC_ARB_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_stall (perf_stall)
`endif
  );

  function automatic logic [31:0] core_fn(logic [31:0] a, logic [31:0] b);
    return a ^ (b << 8) ^ 32'hC0DE_0000;
  endfunction

  // Core model: sees cor_valid on the edge after issue, result stable L edges later.
  logic [31:0] cm [L+1];
  always @(negedge clk) begin
    cm[0] <= core_fn(cor_dataa, cor_datab);
    for (int i = 1; i <= L; i++) cm[i] <= cm[i-1];
  end
  assign cor_result = cm[L];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    req_dataa = {32'h1111_1111, 32'h2222_2222};
    req_datab = {32'd3, 32'd4};
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 00", req_ready);
    end
    n_checks++;
    if (cor_valid !== 1'b0 || cor_dataa !== 32'h0 || cor_datab !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cor: got v=%b a=%h b=%h want zeros",
               cor_valid, cor_dataa, cor_datab);
    end
    n_checks++;
    if (resp_valid !== 2'b00 || resp_result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_resp: got v=%b r=%h want zeros", resp_valid, resp_result);
    end
    req_valid = 2'b00;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    a = 32'h3F060A92;
    b = 32'd2;
    e = core_fn(a, b);
    req_valid = 2'b01;
    req_dataa = {32'hDEAD_BEEF, a};
    req_datab = {32'd9, b};
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL single_grant: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (cor_valid !== 1'b1 || cor_dataa !== a || cor_datab !== b) begin
      n_fail++;
      $display("FAIL single_issue: got v=%b a=%h b=%h want 1 %h %h",
               cor_valid, cor_dataa, cor_datab, a, b);
    end
    for (int c = 1; c <= L + 2; c++) begin
      tick();
      if (c == 1) begin
        n_checks++;
        if (cor_valid !== 1'b0 || cor_dataa !== a) begin
          n_fail++;
          $display("FAIL single_hold: got v=%b a=%h want 0 %h", cor_valid, cor_dataa, a);
        end
      end
      n_checks++;
      if (resp_valid !== ((c == L + 1) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL single_rv c=%0d: got %b", c, resp_valid);
      end
      if (c == L + 1) begin
        n_checks++;
        if (resp_result !== e) begin
          n_fail++;
          $display("FAIL single_result: got %h want %h", resp_result, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [2];
    logic [31:0] b [2];
    a[0] = 32'h3F490FDB;
    b[0] = 32'd22;
    a[1] = 32'h3E860A92;
    b[1] = 32'd23;
    for (int i = 0; i < 2; i++) begin
      req_valid = 2'b10;
      req_dataa = {a[i], 32'h0};
      req_datab = {b[i], 32'h0};
      #1;
      n_checks++;
      if (req_ready !== 2'b10) begin
        n_fail++;
        $display("FAIL b2b_grant%0d: got %b want 10", i, req_ready);
      end
      tick();
    end
    req_valid = 2'b00;
    for (int c = 2; c <= L + 3; c++) begin
      tick();
      n_checks++;
      if (resp_valid !== ((c == L + 1 || c == L + 2) ? 2'b10 : 2'b00)) begin
        n_fail++;
        $display("FAIL b2b_rv c=%0d: got %b", c, resp_valid);
      end
      if (c == L + 1 || c == L + 2) begin
        n_checks++;
        if (resp_result !== core_fn(a[c-L-1], b[c-L-1])) begin
          n_fail++;
          $display("FAIL b2b_result c=%0d: got %h want %h", c, resp_result,
                   core_fn(a[c-L-1], b[c-L-1]));
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] e [4];
    logic [1:0]  w [4];
    logic [31:0] a0;
    logic [31:0] a1;
    for (int i = 0; i < 4; i++) begin
      a0 = 32'h1000_0000 + 32'(i);
      a1 = 32'h2000_0000 + 32'(i);
      req_valid = 2'b11;
      req_dataa = {a1, a0};
      req_datab = {32'(i + 8), 32'(i)};
      w[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
      e[i] = (i % 2 == 0) ? core_fn(a0, 32'(i)) : core_fn(a1, 32'(i + 8));
      #1;
      n_checks++;
      if (req_ready !== w[i]) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, w[i]);
      end
      tick();
    end
    req_valid = 2'b00;
    for (int c = 4; c <= L + 5; c++) begin
      tick();
      if (c >= L + 1 && c <= L + 4) begin
        n_checks++;
        if (resp_valid !== w[c-L-1] || resp_result !== e[c-L-1]) begin
          n_fail++;
          $display("FAIL rr_resp c=%0d: got %b %h want %b %h", c, resp_valid,
                   resp_result, w[c-L-1], e[c-L-1]);
        end
      end else begin
        n_checks++;
        if (resp_valid !== 2'b00) begin
          n_fail++;
          $display("FAIL rr_idle c=%0d: got %b want 00", c, resp_valid);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int bad;
    req_valid = 2'b01;
    req_dataa = {32'h0, 32'h4049_0FDB};
    req_datab = {32'h0, 32'd5};
    tick();
    req_valid = 2'b00;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (cor_valid !== 1'b0 || cor_dataa !== 32'h0 || resp_valid !== 2'b00 ||
        resp_result !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_zero: got v=%b a=%h rv=%b r=%h want zeros",
               cor_valid, cor_dataa, resp_valid, resp_result);
    end
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 2 * L; c++) begin
      tick();
      if (resp_valid !== 2'b00) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midrst_noresp: got %0d pulses want 0", bad);
    end
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL midrst_first: got %b want 01", req_ready);
    end
    req_valid = 2'b00;
    tick();
  endtask

`ifdef CORDIC_ARB_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 2'b01;
      req_dataa = {32'h0, 32'(i)};
      req_datab = {32'h0, 32'd1};
      tick();
    end
    req_valid = 2'b00;
    n_checks++;
    if (perf_issued !== 32'd10 || perf_stall !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_count: got %0d/%0d want 10/0", perf_issued, perf_stall);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (perf_issued !== 32'd0 || perf_stall !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_issued, perf_stall);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_dataa = '0;
    req_datab = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_mid_reset();
`ifdef CORDIC_ARB_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_arb.md
CORDIC_ARB -- requirements
Module: cordic_arb

Interface
REQ-001 SHALL have parameter LATENCY, default 16: clock edges from a cor_valid-high edge to the edge where the matching cor_result is stable.
REQ-002 SHALL have parameter NREQ, default 2: number of requester ports (2..4).
REQ-003 SHALL have port clk  input  1  the single clock; all flops rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 SHALL have port req_dataa  input  NREQ*32  per-requester float32 angle operand.
REQ-007 SHALL have port req_datab  input  NREQ*32  per-requester function/iteration selector.
REQ-008 SHALL have port req_ready  output  NREQ  one-hot grant; a transfer occurs on a clock edge where req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port resp_valid  output  NREQ  one-cycle result strobe per requester.
REQ-010 SHALL have port resp_result  output  32  result, shared by all requesters, qualified by resp_valid.
REQ-011 SHALL have port cor_valid  output  1  issue strobe to the CORDIC core.
REQ-012 SHALL have ports cor_dataa and cor_datab  output  32 each  operands to the core.
REQ-013 SHALL have port cor_result  input  32  core output.

Function
REQ-014 req_ready SHALL be combinational: at most one bit high, and only for a requester with req_valid high.
REQ-015 Arbitration SHALL be round-robin: search starts at the index after the last granted requester and wraps from NREQ-1 to 0.
REQ-016 At most one operation SHALL issue per cycle, and the block SHALL sustain one issue every cycle; there is no occupancy limit.
REQ-017 On a transfer edge, cor_valid, cor_dataa and cor_datab SHALL register the granted operands; cor_valid SHALL be 0 on every other edge, with the operands held.
REQ-018 A tag pipeline SHALL carry {valid, requester id} for every issue, aligned so that cor_result is sampled exactly LATENCY edges after the issue edge.
REQ-019 resp_valid[id] SHALL be high for exactly one cycle, LATENCY+1 edges after the accepting edge, with resp_result holding the sampled cor_result.
REQ-020 Responses SHALL return in issue order and SHALL NOT be back-pressured.
REQ-021 A requester SHALL be allowed to issue again while its earlier results are still in flight.
REQ-022 The grant pointer SHALL advance only on a transfer; it SHALL NOT advance on idle cycles.
REQ-023 When a requester deasserts req_valid without a transfer, no state SHALL change.

Reset
REQ-024 While rst is high: req_ready=0, resp_valid=0, resp_result=0, cor_valid=0, cor_dataa=0, cor_datab=0, and all tag valids cleared.
REQ-025 The reset value of the grant pointer SHALL be NREQ-1, so requester 0 wins first.
REQ-026 Reset mid-operation SHALL discard all in-flight tags; no resp_valid SHALL be produced for pre-reset issues.

Configuration
REQ-027 Macro CORDIC_ARB_PERF_EN, when defined, SHALL add output perf_issued (32): wrapping count of transfers.
REQ-028 Macro CORDIC_ARB_PERF_EN, when defined, SHALL add output perf_stall (32): wrapping count of cycles with any req_valid high and no transfer, which is only possible during reset.
REQ-029 Both perf counters SHALL be cleared by rst.
REQ-030 Without CORDIC_ARB_PERF_EN, the perf ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Shared package cordic_pkg SHALL hold CORDIC_W=32, the default LATENCY, and typedef req_id_t (2 bits).
REQ-032 The tag shift register SHALL be sub-module cordic_arb_tagpipe (params LATENCY; in: valid, id; out: valid, id).

Verification
REQ-033 After reset, req0 issues dataa=32'h3F060A92, datab=2 -> cor_valid 1 cycle later, then resp_valid[0] LATENCY+1 edges after acceptance, carrying cor_result.
REQ-034 req0 and req1 valid together for 4 cycles -> grants 0,1,0,1 and four responses in that order.
REQ-035 Back-to-back issues from req1 (dataa=32'h3F490FDB/datab=22, then 32'h3E860A92/datab=23) -> two consecutive resp_valid[1] pulses in order.
REQ-036 rst asserted 5 cycles after an issue -> outputs zero immediately; no resp_valid appears within 2*LATENCY cycles after release.
REQ-037 With CORDIC_ARB_PERF_EN, 10 transfers -> perf_issued=10, perf_stall=0; rst pulse -> both counters 0.
